// File: rtl/spi_read_arbiter.sv
// spi_read_arbiter: round-robin arbiter sharing one SPI read master between fetch and data requesters
module spi_read_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        m_start,
  output logic [15:0] m_addr,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic [7:0]  m_data,
  output logic        arb_busy,
  output logic        grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_next;
  logic [9:0] r_cnt;
  logic r_last, w_grant, w_win, w_done, w_tmo, w_fin;
  assign w_grant = ena && !m_busy && (req0 || req1);
  assign w_win = (req0 && req1) ? !r_last : req1;
  assign w_done = r_state == WAIT && m_done;
  assign w_tmo = r_state == WAIT && !m_done && r_cnt == TMO_LAST;
  assign w_fin = w_done || w_tmo;
  assign arb_busy = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_fin ? RESP : WAIT;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_start  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= 8'h00;
      err      <= 1'b0;
      m_addr   <= 16'h0000;
      grant_id <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= 10'd0;
    end else begin
      m_start <= r_state == IDLE && w_grant;
      ack0    <= w_fin && !grant_id;
      ack1    <= w_fin && grant_id;
      r_cnt   <= r_state == WAIT ? r_cnt + 10'd1 : 10'd0;
      if (r_state == IDLE && w_grant) begin
        m_addr   <= w_win ? addr1 : addr0;
        grant_id <= w_win;
      end
      if (w_fin) begin
        rdata <= w_done ? m_data : 8'h00;
        err   <= w_tmo;
      end
      if (r_state == RESP) r_last <= grant_id;
    end
  end
endmodule
